instr_fetch: RTL and testbench

Instruction fetch sequencer: consumes the program counter value, runs one memory read per fetch request, and loads the returned word into the instruction register. It sits between the `pc` register and the memory interface. On success it pulses `inc_pc` back to the PC for exactly one cycle. The control unit starts each fetch with `start` and waits for `done` or `err`.

---
 rtl/instr_fetch_pkg.sv | 12 +
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: the fetch sequencer state encoding and the machine word width.
package instr_fetch_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: one memory read per accepted start, result loaded into the IR,
// with a bounded wait and a sticky timeout flag.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                TIMEOUT  = 15,
    parameter logic [WORD_W-1:0] RESET_IR = 32'h0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [WORD_W-1:0] pc_in,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_data_in,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] ir_out,
    output logic              inc_pc,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = pc_in;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A ready on the final permitted edge still completes the fetch.
                if (mem_ready) begin
                    ir_d    = mem_data_in;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ir_q    <= RESET_IR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes are pure state decodes, so no input reaches an output combinationally.
    assign mem_rd   = (state_q == WAIT);
    assign done     = (state_q == DONE);
    assign inc_pc   = (state_q == DONE);
    assign busy     = (state_q == WAIT) || (state_q == DONE);
    assign mem_addr = addr_q;
    assign ir_out   = ir_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: transaction-level reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_instr_fetch;

    localparam int          TO   = 4;
    localparam logic [31:0] RIR  = 32'hCAFE0001;

    logic        clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] pc_in, mem_data_in;
    logic [31:0] mem_addr, ir_out;
    logic        mem_rd, inc_pc, done, busy, err;

    instr_fetch #(.TIMEOUT(TO), .RESET_IR(RIR)) dut (
        .clock(clock), .clear(clear), .start(start), .pc_in(pc_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data_in(mem_data_in),
        .mem_ready(mem_ready), .ir_out(ir_out), .inc_pc(inc_pc), .done(done),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is either outstanding (with a count of edges already waited),
    // just completed (one-cycle done window), or absent.
    bit          m_active, m_done_win, m_err;
    int          m_waited;
    logic [31:0] m_addr, m_ir;

    initial begin
        forever begin
            @(posedge clock);
            if (!clear) begin
                m_active = 0; m_done_win = 0; m_err = 0; m_waited = 0;
                m_addr = 32'h0; m_ir = RIR;
            end else if (m_done_win) begin
                m_done_win = 0;
            end else if (m_active) begin
                if (mem_ready) begin
                    m_ir = mem_data_in; m_active = 0; m_done_win = 1;
                end else if (m_waited + 1 == TO) begin
                    m_active = 0; m_err = 1;
                end else begin
                    m_waited++;
                end
            end else if (start) begin
                m_addr = pc_in; m_active = 1; m_waited = 0; m_err = 0;
            end
            #1;
            if (chk_en) begin
                chk("model mem_rd", {31'b0, mem_rd}, {31'b0, m_active});
                chk("model done", {31'b0, done}, {31'b0, m_done_win});
                chk("model inc_pc", {31'b0, inc_pc}, {31'b0, m_done_win});
                chk("model busy", {31'b0, busy}, {31'b0, m_active | m_done_win});
                chk("model err", {31'b0, err}, {31'b0, m_err});
                chk("model mem_addr", mem_addr, m_addr);
                chk("model ir_out", ir_out, m_ir);
            end
        end
    end

    int rd_cnt, done_cnt, inc_cnt;

    task automatic clr_cnt();
        rd_cnt = 0; done_cnt = 0; inc_cnt = 0;
    endtask

    // Advance to the next falling edge and tally the strobes seen in that cycle.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (mem_rd === 1'b1) rd_cnt++;
            if (done === 1'b1)   done_cnt++;
            if (inc_pc === 1'b1) inc_cnt++;
        end
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; mem_ready = 1'b0; pc_in = '0; mem_data_in = '0;
        clr_cnt();
        tick(2);
        chk_en = 1'b1;
        chk("reset mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset ir_out", ir_out, RIR);
        chk("reset busy/err/done", {29'b0, busy, err, done}, 32'd0);
        clear = 1'b1;
        tick(1);

        // Normal fetch: ready on the 3rd WAIT edge.
        pc_in = 32'h10; start = 1'b1; clr_cnt();
        tick(1); start = 1'b0;
        tick(2); mem_ready = 1'b1; mem_data_in = 32'hDEADBEEF;
        tick(1); mem_ready = 1'b0;
        tick(2);
        chk("normal rd cycles", rd_cnt, 32'd3);
        chk("normal done pulses", done_cnt, 32'd1);
        chk("normal inc pulses", inc_cnt, 32'd1);
        chk("normal ir_out", ir_out, 32'hDEADBEEF);
        chk("normal mem_addr", mem_addr, 32'h10);

        // Start pulses in WAIT and in DONE are dropped.
        pc_in = 32'h20; start = 1'b1; clr_cnt();
        tick(1); start = 1'b0; pc_in = 32'h99;
        tick(1); start = 1'b1;
        tick(1); start = 1'b0; mem_ready = 1'b1; mem_data_in = 32'h11111111;
        tick(1); mem_ready = 1'b0; start = 1'b1;
        tick(1); start = 1'b0;
        tick(2);
        chk("ignored mem_addr", mem_addr, 32'h20);
        chk("ignored done pulses", done_cnt, 32'd1);
        chk("ignored rd cycles", rd_cnt, 32'd3);
        chk("ignored ir_out", ir_out, 32'h11111111);

        // Timeout: no ready at all.
        pc_in = 32'h30; start = 1'b1; clr_cnt();
        tick(1); start = 1'b0;
        tick(5);
        chk("timeout rd cycles", rd_cnt, TO);
        chk("timeout err", {31'b0, err}, 32'd1);
        chk("timeout done pulses", done_cnt, 32'd0);
        chk("timeout ir_out", ir_out, 32'h11111111);
        chk("timeout mem_addr", mem_addr, 32'h30);

        // Ready on the last permitted WAIT edge beats the timeout; the new start clears err.
        pc_in = 32'h40; start = 1'b1; clr_cnt();
        tick(1); start = 1'b0;
        chk("err cleared by start", {31'b0, err}, 32'd0);
        tick(3); mem_ready = 1'b1; mem_data_in = 32'h44;
        tick(1); mem_ready = 1'b0;
        chk("boundary done", {31'b0, done}, 32'd1);
        tick(2);
        chk("boundary ir_out", ir_out, 32'h44);
        chk("boundary err", {31'b0, err}, 32'd0);

        // Zero-wait memory with start held: one fetch every 3 cycles.
        mem_ready = 1'b1; start = 1'b1; clr_cnt();
        for (int i = 0; i < 12; i++) begin
            pc_in = 32'h100 + 32'(4 * i); mem_data_in = 32'hA000 + 32'(i);
            tick(1);
        end
        start = 1'b0; mem_ready = 1'b0;
        tick(3);
        chk("zero-wait inc pulses", inc_cnt, 32'd4);
        chk("zero-wait done pulses", done_cnt, 32'd4);
        chk("zero-wait rd cycles", rd_cnt, 32'd4);
        chk("zero-wait last addr", mem_addr, 32'h124);

        // Reset during WAIT, then a late ready that must be ignored.
        pc_in = 32'h50; start = 1'b1; clr_cnt();
        tick(1); start = 1'b0;
        tick(1); clear = 1'b0;
        tick(1); clear = 1'b1; mem_ready = 1'b1; mem_data_in = 32'h55;
        tick(1); mem_ready = 1'b0;
        tick(2);
        chk("abort done pulses", done_cnt, 32'd0);
        chk("abort mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("abort ir_out", ir_out, RIR);
        chk("abort mem_addr", mem_addr, 32'h0);
        chk("abort busy", {31'b0, busy}, 32'd0);

        // Reset while idle after a completed fetch.
        pc_in = 32'h60; start = 1'b1;
        tick(1); start = 1'b0; mem_ready = 1'b1; mem_data_in = 32'h66;
        tick(1); mem_ready = 1'b0;
        tick(2);
        chk("pre-reset ir_out", ir_out, 32'h66);
        clear = 1'b0;
        tick(1); clear = 1'b1;
        chk("idle reset ir_out", ir_out, RIR);
        chk("idle reset mem_addr", mem_addr, 32'h0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
